// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types, latency defaults and width helpers for the DE scoreboard
//
// Contents:
//   SB_NREG_DEF, SB_LOAD_LAT_DEF, SB_ALU_LAT_DEF : default configuration
//   reg_idx_t                                    : architectural register index (full RV32I width)
//   sb_max_lat(a, b)                             : larger of the two writer latencies
//   sb_cnt_w(max_lat)                            : countdown width able to hold max_lat, at least 1
package sb_pkg;

    localparam int SB_NREG_DEF     = 32;
    localparam int SB_LOAD_LAT_DEF = 1;
    localparam int SB_ALU_LAT_DEF  = 0;

    typedef logic [$clog2(SB_NREG_DEF)-1:0] reg_idx_t;

    function automatic int sb_max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sb_cnt_w(input int max_lat);
        int w;
        w = $clog2(max_lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one per-register countdown of remaining hazard cycles
//
// Ports:
//   clk      in  pipeline clock
//   rst_n    in  asynchronous active-low reset, clears the count
//   load     in  a writer to this register issues this cycle
//   load_val in  CW  cycles the new writer keeps the register unavailable
//   busy     out register still has stall cycles outstanding
module sb_entry
    import sb_pkg::*;
#(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt;

    // A reload replaces the old count outright: the youngest writer decides
    // readiness, and a reload never also decrements in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/de_load_scoreboard.sv
// rtl/de_load_scoreboard.sv - decode-stage hazard scoreboard driving PC, FE/DE and DE/EX controls
//
// Optional feature macro: SB_PERF_EN adds the stall_cycles performance counter port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   de_valid                    DE holds a real instruction
//   de_rs1, de_rs2              source indices; de_use_rs1/de_use_rs2 say whether each is read
//   de_rd, de_ru_wr, de_dm_rd   destination index, writes-rd flag, is-load flag
//   ex_flush                    EX resolved a taken branch/jump; DE instruction is killed
//   stall                       hold PC and FE/DE
//   pc_wr, fd_wr                PC and FE/DE write enables (inverse of stall)
//   de_clr                      bubble into DE/EX
//   stall_cycles                saturating count of stalled cycles (SB_PERF_EN only)
module de_load_scoreboard
    import sb_pkg::*;
#(
    parameter  int NREG     = SB_NREG_DEF,
    parameter  int LOAD_LAT = SB_LOAD_LAT_DEF,
    parameter  int ALU_LAT  = SB_ALU_LAT_DEF,
    localparam int AW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_valid,
    input  logic [AW-1:0] de_rs1,
    input  logic [AW-1:0] de_rs2,
    input  logic          de_use_rs1,
    input  logic          de_use_rs2,
    input  logic [AW-1:0] de_rd,
    input  logic          de_ru_wr,
    input  logic          de_dm_rd,
    input  logic          ex_flush,
    output logic          stall,
    output logic          pc_wr,
    output logic          fd_wr,
    output logic          de_clr
`ifdef SB_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int MAX_LAT = sb_max_lat(LOAD_LAT, ALU_LAT);
    localparam int CW      = sb_cnt_w(MAX_LAT);

    logic [NREG-1:0] busy;
    logic            hazard;
    logic            issue;
    logic            wr_en;
    logic [CW-1:0]   load_val;

    // x0 has no counter; tying its busy bit low makes reads of x0 hazard-free
    // without a separate zero compare on each source.
    assign busy[0] = 1'b0;

    assign wr_en    = issue & de_ru_wr;
    assign load_val = de_dm_rd ? CW'(LOAD_LAT) : CW'(ALU_LAT);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .CW (CW)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (wr_en & (de_rd == AW'(r))),
            .load_val (load_val),
            .busy     (busy[r])
        );
    end

    assign hazard = de_valid & ((de_use_rs1 & busy[de_rs1]) | (de_use_rs2 & busy[de_rs2]));

    // Flush beats stall so the PC is free to take the branch target.
    assign stall  = hazard & ~ex_flush;
    assign issue  = de_valid & ~stall & ~ex_flush;
    assign pc_wr  = ~stall;
    assign fd_wr  = ~stall;
    // Pending state is cleared asynchronously, so stall is already low during
    // reset; the bubble is forced here to keep DE/EX empty until release.
    assign de_clr = stall | ex_flush | ~rst_n;

`ifdef SB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_de_load_scoreboard.sv
// tb/tb_de_load_scoreboard.sv - self-checking bench for de_load_scoreboard (LOAD_LAT 1 and 2)
module tb_de_load_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       de_valid;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       de_use_rs1, de_use_rs2, de_ru_wr, de_dm_rd, ex_flush;

    logic       s1, pw1, fw1, dc1;
    logic       s2, pw2, fw2, dc2;
`ifdef SB_PERF_EN
    logic [31:0] sc1, sc2;
`endif

    int checks = 0;
    int errors = 0;

    de_load_scoreboard #(.NREG(32), .LOAD_LAT(1), .ALU_LAT(0)) u_l1 (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_rd(de_rd), .de_ru_wr(de_ru_wr), .de_dm_rd(de_dm_rd), .ex_flush(ex_flush),
        .stall(s1), .pc_wr(pw1), .fd_wr(fw1), .de_clr(dc1)
`ifdef SB_PERF_EN
        , .stall_cycles(sc1)
`endif
    );

    de_load_scoreboard #(.NREG(32), .LOAD_LAT(2), .ALU_LAT(0)) u_l2 (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_rd(de_rd), .de_ru_wr(de_ru_wr), .de_dm_rd(de_dm_rd), .ex_flush(ex_flush),
        .stall(s2), .pc_wr(pw2), .fd_wr(fw2), .de_clr(dc2)
`ifdef SB_PERF_EN
        , .stall_cycles(sc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: for each register, the first cycle number in which a consumer may
    // issue. A writer issuing in cycle c with latency L makes it c+1+L.
    int cyc = 0;
    int rdy [2][32];
    int lat [2] = '{1, 2};
    int perf [2];

    function automatic logic m_stall(input int d);
        logic haz;
        haz = de_valid &&
              ((de_use_rs1 && de_rs1 != 0 && cyc < rdy[d][de_rs1]) ||
               (de_use_rs2 && de_rs2 != 0 && cyc < rdy[d][de_rs2]));
        return rst_n && haz && !ex_flush;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            perf[d] = 0;
            for (int r = 0; r < 32; r++) rdy[d][r] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    perf[d] = 0;
                    for (int r = 0; r < 32; r++) rdy[d][r] = 0;
                end else begin
                    if (m_stall(d)) perf[d] = perf[d] + 1;
                    if (de_valid && !m_stall(d) && !ex_flush && de_ru_wr && de_rd != 0)
                        rdy[d][de_rd] = cyc + 1 + (de_dm_rd ? lat[d] : 0);
                end
            end
            cyc++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic e1, e2;
        forever begin
            @(negedge clk);
            e1 = m_stall(0);
            e2 = m_stall(1);
            chk("l1_stall", {31'd0, s1}, {31'd0, e1});
            chk("l1_pc_wr", {31'd0, pw1}, {31'd0, !e1});
            chk("l1_fd_wr", {31'd0, fw1}, {31'd0, !e1});
            chk("l1_de_clr", {31'd0, dc1}, {31'd0, e1 || ex_flush || !rst_n});
            chk("l2_stall", {31'd0, s2}, {31'd0, e2});
            chk("l2_pc_wr", {31'd0, pw2}, {31'd0, !e2});
            chk("l2_fd_wr", {31'd0, fw2}, {31'd0, !e2});
            chk("l2_de_clr", {31'd0, dc2}, {31'd0, e2 || ex_flush || !rst_n});
`ifdef SB_PERF_EN
            chk("l1_stall_cycles", sc1, rst_n ? perf[0] : 0);
            chk("l2_stall_cycles", sc2, rst_n ? perf[1] : 0);
`endif
        end
    end

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic fl);
        de_valid = v; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
        de_rd = rd; de_ru_wr = wr; de_dm_rd = ld; ex_flush = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw(input logic [4:0] rd);
        drive(1, 0, 0, 0, 0, rd, 1, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_stall", {31'd0, s1}, 32'd0);
        chk("rst_pc_wr", {31'd0, pw1}, 32'd1);
        chk("rst_de_clr", {31'd0, dc1}, 32'd1);
        step();
        rst_n = 1'b1;
        nop(); step();

        // lw x5 ; add x6,x5,x1
        lw(5);
        chk("t1_lw_nostall", {31'd0, s1}, 32'd0);
        step();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("t1_l1_stall", {31'd0, s1}, 32'd1);
        chk("t1_l1_de_clr", {31'd0, dc1}, 32'd1);
        chk("t1_l1_pc_wr", {31'd0, pw1}, 32'd0);
        chk("t1_l2_stall_a", {31'd0, s2}, 32'd1);
        step();
        chk("t1_l1_issue", {31'd0, s1}, 32'd0);
        chk("t1_l2_stall_b", {31'd0, s2}, 32'd1);
        step();
        chk("t1_l2_issue", {31'd0, s2}, 32'd0);
        step(); nop(); step(); step();

        // lw x0 ; add x6,x0,x0
        lw(0);
        step();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0);
        chk("t2_x0_l1", {31'd0, s1}, 32'd0);
        chk("t2_x0_l2", {31'd0, s2}, 32'd0);
        step(); nop(); step();

        // lw x7 ; independent ; use x7
        lw(7);
        step();
        drive(1, 1, 1, 2, 1, 8, 1, 0, 0);
        step();
        drive(1, 0, 0, 7, 1, 9, 1, 0, 0);
        chk("t3_gap_l1", {31'd0, s1}, 32'd0);
        chk("t3_gap_l2", {31'd0, s2}, 32'd1);
        step();
        chk("t3_gap_l2_issue", {31'd0, s2}, 32'd0);
        step(); nop(); step(); step();

        // lw x10 ; flushed lw x9 that reads x10 ; use x9
        lw(10);
        step();
        drive(1, 10, 1, 0, 0, 9, 1, 1, 1);
        chk("t4_flush_stall", {31'd0, s1}, 32'd0);
        chk("t4_flush_pc_wr", {31'd0, pw1}, 32'd1);
        chk("t4_flush_de_clr", {31'd0, dc1}, 32'd1);
        chk("t4_flush_l2", {31'd0, s2}, 32'd0);
        step();
        drive(1, 9, 1, 0, 0, 11, 1, 0, 0);
        chk("t4_x9_l1", {31'd0, s1}, 32'd0);
        chk("t4_x9_l2", {31'd0, s2}, 32'd0);
        step(); nop(); step(); step(); step();

        // WAW: lw x5 ; addi x5,x0,3 ; use x5
        lw(5);
        step();
        drive(1, 0, 1, 0, 0, 5, 1, 0, 0);
        chk("t5_addi", {31'd0, s1}, 32'd0);
        step();
        drive(1, 5, 1, 5, 1, 12, 1, 0, 0);
        chk("t5_waw_l1", {31'd0, s1}, 32'd0);
        chk("t5_waw_l2", {31'd0, s2}, 32'd0);
        step(); nop(); step(); step();

        // Reset pulsed during a load-use stall
        lw(5);
        step();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk("t6_pre_stall", {31'd0, s1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stall_l1", {31'd0, s1}, 32'd0);
        chk("t6_rst_stall_l2", {31'd0, s2}, 32'd0);
        chk("t6_rst_pc_wr", {31'd0, pw1}, 32'd1);
        chk("t6_rst_fd_wr", {31'd0, fw1}, 32'd1);
        chk("t6_rst_de_clr", {31'd0, dc1}, 32'd1);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_post_l1", {31'd0, s1}, 32'd0);
        chk("t6_post_l2", {31'd0, s2}, 32'd0);
`ifdef SB_PERF_EN
        chk("t6_perf_zero", sc1, 32'd0);
`endif
        step();
        lw(5);
        step();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk("t6_again_stall", {31'd0, s1}, 32'd1);
        step();
        chk("t6_again_issue", {31'd0, s1}, 32'd0);
`ifdef SB_PERF_EN
        chk("t6_perf_one", sc1, 32'd1);
`endif
        step(); nop(); step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/de_load_scoreboard.md
# de_load_scoreboard

Parametrised decode-stage hazard scoreboard for the pipelined RV32 core. It generalises fixed load-use detection to per-register countdown tracking. Load and ALU result latencies, register count and source-port usage are configurable. It sits beside the register unit in DE and drives the PC, FE/DE and DE/EX pipeline-register controls.

## Interface
Parameters:
- NREG, 32: architectural registers; 16 gives RV32E. x0 is never tracked.
- LOAD_LAT, 1: stall cycles a load imposes on an immediately following consumer. Range 0..7.
- ALU_LAT, 0: stall cycles a non-load writer imposes. 0 means full forwarding. Range 0..7.

Ports (AW = $clog2(NREG)):
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- de_valid  in  1  DE holds a real instruction.
- de_rs1, de_rs2  in  AW  source register indices.
- de_use_rs1, de_use_rs2  in  1  the instruction actually reads that source.
- de_rd  in  AW  destination index.
- de_ru_wr  in  1  the instruction writes rd (RuWr).
- de_dm_rd  in  1  the instruction is a load (DMRd).
- ex_flush  in  1  taken branch or jump resolved in EX; kills the DE instruction.
- stall  out  1  hold PC and FE/DE.
- pc_wr  out  1  PC write enable; equals !stall.
- fd_wr  out  1  FE/DE write enable; equals !stall.
- de_clr  out  1  insert a bubble into DE/EX.
- stall_cycles  out  32  present only with SB_PERF_EN.

## Operation
- State: one counter pend[r] per register r = 1..NREG-1. CW = $clog2(max(LOAD_LAT, ALU_LAT)+1), minimum 1.
- hazard = de_valid & ((de_use_rs1 & de_rs1≠0 & pend[de_rs1]≠0) | (same for rs2)).
- stall = hazard & !ex_flush. Flush wins so the PC can load the branch target.
- de_clr = stall | ex_flush.
- issue = de_valid & !stall & !ex_flush.
- On issue with de_ru_wr and de_rd≠0: pend[de_rd] loads LOAD_LAT if de_dm_rd, else ALU_LAT.
  - This overwrites any nonzero value. WAW: the younger writer defines readiness.
- Every other nonzero pend decrements by 1 each cycle. Counters never wrap below 0.
- A counter reloaded by issue does not also decrement that cycle.
- A killed (flushed or stalled) instruction never sets pend.
- Writes to x0 are ignored. Reads of x0 never hazard.

## Timing
- stall, de_clr, pc_wr and fd_wr are combinational from the inputs and the registered pend. There is no added latency.
- pend updates on the rising edge of clk.
- Load issued at edge N, LOAD_LAT=L: a dependent in DE stalls from cycle N+1 through N+L and issues in cycle N+L+1.
- With one independent instruction in between, the dependent stalls L-1 cycles. This is 0 for L=1.
- Reset values, asserted asynchronously:
  - all pend = 0
  - stall = 0, pc_wr = 1, fd_wr = 1
  - de_clr = 1 while rst_n is low
  - stall_cycles = 0
- Reset mid-stall discards all pending state. The first cycle after release never stalls.

## Configuration
- SB_PERF_EN defined:
  - stall_cycles increments on every clk edge where stall=1.
  - It saturates at 32'hFFFF_FFFF and clears only on reset.
- SB_PERF_EN undefined:
  - the stall_cycles port and its counter do not exist.
  - All other behaviour is identical.

## Structure
- Package sb_pkg holds:
  - reg_idx_t
  - the LOAD_LAT and ALU_LAT defaults
  - the sb_cnt_w(max_lat) width function
  - the max-latency localparam helper
- Sub-module sb_entry holds one countdown counter, with ports clk, rst_n, load, load_val and busy.
  - It is generated for r = 1..NREG-1.
  - Top level does index decode, hazard OR-reduction and the perf counter.

## Test plan
- lw x5 then add x6,x5,x1 (LOAD_LAT=1): stall=1 and de_clr=1 for exactly one cycle; the add issues the following cycle.
- lw x0 then add x6,x0,x0: no stall; pend stays all-zero.
- LOAD_LAT=2: lw x7 then use x7 gives 2 stall cycles. lw x7, independent op, then use x7 gives 1 stall cycle.
- Hazard and ex_flush in the same cycle: stall=0, pc_wr=1, de_clr=1. A flushed lw x9 leaves pend[9]=0, so a later use of x9 does not stall.
- WAW, ALU_LAT=0: lw x5 then addi x5,x0,3 then use x5: no stall on the consumer.
- rst_n pulsed low during a load-use stall: stall drops immediately and pend clears. With SB_PERF_EN, stall_cycles reads 0 after reset and 1 after one subsequent load-use stall.
